// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution unit fed by the one-hot ALU select from alu_control_unit.
//   Operands are taken on a valid/ready handshake. ADD, SUB, AND, OR and NOT
//   complete in one cycle. SHR/SHL shift one bit per cycle under a small
//   FSM, so in_ready drops for shamt cycles.
//   Maintains the condition-code register ccr = {C, N, Z}.
//
//   Build option:
//     ALU_BARREL_SHIFT_EN - shifts use a combinational barrel shifter and
//                           complete in one cycle. The SHIFT state is not
//                           built and in_ready stays 1.
//
//   Ports
//     clk, rst_n      clock (rising edge), synchronous active-low reset
//     alu_sel         one-hot op: [0]ADD [1]SUB [2]AND [3]OR [4]NOT [5]SHR [6]SHL, 0 = NOP
//     op_a, op_b      operands
//     shamt           shift amount
//     in_valid        request; in_ready = unit can accept
//     flag_set_c      force C to 1 (SETC)
//     flag_clr_c      force C to 0 (CLRC)
//     out_valid       one-cycle pulse: result/ccr updated
//     result          registered result
//     ccr             {C, N, Z}
//     err             one-cycle pulse with out_valid: alu_sel was not one-hot
//
//   FSM (iterative shifter only)
//     state | meaning
//     IDLE  | ready; single-cycle ops complete here
//     SHIFT | shifting work_q one bit per edge until cnt_q reaches 0
//
//   SHAMT_W must satisfy 2**SHAMT_W >= WIDTH.
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         alu_sel,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flag_set_c,
  input  logic               flag_clr_c,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [2:0]         ccr,
  output logic               err
);

  logic             out_valid_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       ccr_q;

  logic             accept;
  logic             sel_nop;
  logic             sel_onehot;
  logic [WIDTH:0]   sum_w;

  logic             fin_valid;
  logic             fin_err;
  logic             fin_wr;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_c_upd;
  logic             start_shift;

  logic             c_d;
  logic [2:0]       ccr_d;
  logic [WIDTH-1:0] result_d;

`ifdef ALU_BARREL_SHIFT_EN
  // One guard bit catches the last bit shifted out.
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;

  assign shl_ext  = {1'b0, op_a} << shamt;
  assign shr_ext  = {op_a, 1'b0} >> shamt;
  assign in_ready = 1'b1;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     work_q;
  logic                 dir_left_q;
  logic [WIDTH-1:0]     step_res;
  logic                 step_c;

  assign step_res = dir_left_q ? (work_q << 1) : (work_q >> 1);
  assign step_c   = dir_left_q ? work_q[WIDTH-1] : work_q[0];
  assign in_ready = (state_q == IDLE);
`endif

  assign accept     = in_valid & in_ready;
  assign sel_nop    = (alu_sel == 7'd0);
  assign sel_onehot = !sel_nop && ((alu_sel & (alu_sel - 7'd1)) == 7'd0);
  assign sum_w      = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    fin_valid   = 1'b0;
    fin_err     = 1'b0;
    fin_wr      = 1'b0;
    fin_res     = result_q;
    fin_c       = ccr_q[2];
    fin_c_upd   = 1'b0;
    start_shift = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    if (state_q == SHIFT) begin
      if (cnt_q == SHAMT_W'(1)) begin
        fin_valid = 1'b1;
        fin_wr    = 1'b1;
        fin_res   = step_res;
        fin_c     = step_c;
        fin_c_upd = 1'b1;
      end
    end else
`endif
    if (accept) begin
      fin_valid = 1'b1;
      if (!sel_nop) begin
        if (!sel_onehot) begin
          fin_err = 1'b1;
        end else begin
          fin_wr = 1'b1;
          if (alu_sel[0]) begin
            fin_res   = sum_w[WIDTH-1:0];
            fin_c     = sum_w[WIDTH];
            fin_c_upd = 1'b1;
          end else if (alu_sel[1]) begin
            fin_res   = op_a - op_b;
            fin_c     = (op_a < op_b);
            fin_c_upd = 1'b1;
          end else if (alu_sel[2]) begin
            fin_res = op_a & op_b;
          end else if (alu_sel[3]) begin
            fin_res = op_a | op_b;
          end else if (alu_sel[4]) begin
            fin_res = ~op_a;
          end else if (shamt == '0) begin
            fin_res = op_a;
          end else begin
`ifdef ALU_BARREL_SHIFT_EN
            fin_c_upd = 1'b1;
            if (alu_sel[6]) begin
              fin_res = shl_ext[WIDTH-1:0];
              fin_c   = shl_ext[WIDTH];
            end else begin
              fin_res = shr_ext[WIDTH:1];
              fin_c   = shr_ext[0];
            end
`else
            // Result and flags are written when the shift finishes.
            fin_valid   = 1'b0;
            fin_wr      = 1'b0;
            start_shift = 1'b1;
`endif
          end
        end
      end
    end
  end

  // SETC/CLRC win over the op's carry; asserting both is treated as no command.
  always_comb begin
    if (flag_set_c != flag_clr_c) begin
      c_d = flag_set_c;
    end else if (fin_c_upd) begin
      c_d = fin_c;
    end else begin
      c_d = ccr_q[2];
    end
    if (fin_wr) begin
      ccr_d    = {c_d, fin_res[WIDTH-1], (fin_res == '0)};
      result_d = fin_res;
    end else begin
      ccr_d    = {c_d, ccr_q[1:0]};
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      ccr_q       <= 3'b000;
`ifndef ALU_BARREL_SHIFT_EN
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      dir_left_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= fin_valid;
      err_q       <= fin_err;
      result_q    <= result_d;
      ccr_q       <= ccr_d;
`ifndef ALU_BARREL_SHIFT_EN
      case (state_q)
        IDLE: begin
          if (start_shift) begin
            work_q     <= op_a;
            cnt_q      <= shamt;
            dir_left_q <= alu_sel[6];
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= step_res;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= IDLE;
          end
        end
      endcase
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign result    = result_q;
  assign ccr       = ccr_q;

endmodule
